mult_div: RTL and testbench
===========================

# mult_div

Multi-cycle multiply/divide unit sitting in the EX stage beside the ALU, fed by the same operand buses A and B from the ID/EX register. It executes mult, multu, div and divu with a fixed latency, and writes the HI/LO register pair directly for mthi and mtlo. Busy tells the hazard unit to stall any following multiply/divide or mfhi/mflo instruction. HI and LO feed the EX-stage result mux.

## Interface
- MULT_CYCLES, 5, cycles Busy stays high for mult/multu; legal range 1..15
- DIV_CYCLES, 10, cycles Busy stays high for div/divu; legal range 1..15
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
- A  input  32  operand rs; dividend for div/divu; write data for mthi/mtlo
- B  input  32  operand rt; divisor for div/divu
- MDOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no effect)
- Start  input  1  sampled each edge; qualifies MDOp
- Busy  output  1  operation in flight
- HI  output  32  HI register
- LO  output  32  LO register

## Operation
- State: HI, LO, a 4-bit count, and pending PHI/PLO. Busy = (count != 0), decoded combinationally from the registered count.
- Accept: Start=1 and Busy=0 at a rising edge.
- Busy=1 at an edge: Start and MDOp are ignored entirely. No queueing, no error flag.
- mult: {PHI,PLO} <= $signed(A) * $signed(B), a 64-bit signed product. count <= MULT_CYCLES.
- multu: {PHI,PLO} <= the 64-bit unsigned product. count <= MULT_CYCLES.
- div:
  - PLO <= signed quotient, truncated toward zero.
  - PHI <= signed remainder, with the sign of the dividend.
  - count <= DIV_CYCLES.
- divu: PLO <= unsigned quotient, PHI <= unsigned remainder. count <= DIV_CYCLES.
- Divide by zero (B=0, div or divu): PHI <= HI and PLO <= LO, so HI/LO end up unchanged. Busy still lasts DIV_CYCLES.
- Overflow (div with A=0x80000000, B=0xFFFFFFFF): PLO <= 0x80000000, PHI <= 0x00000000.
- mthi: HI <= A at the accepting edge; count stays 0; no busy period.
- mtlo: LO <= A at the accepting edge; count stays 0; no busy period.
- MDOp 0 or 7 with Start=1: no state change.
- Counting: while count != 0, count decrements each edge. On the edge where count goes 1 -> 0, HI <= PHI and LO <= PLO.
- HI/LO hold their old values for the whole busy period; the result is never partially visible.

## Timing
- Reset values: Busy=0, HI=0, LO=0, count=0, PHI=0, PLO=0.
- Multiply/divide accepted at edge k with latency N:
  - Busy=1 in cycles k+1 .. k+N.
  - HI/LO take the new values at edge k+N.
  - Busy=0 and the new HI/LO are visible from the cycle after edge k+N.
- mthi/mtlo accepted at edge k: the new value is visible in the cycle after edge k; Busy stays 0.
- Back-to-back: Start held high on the same cycle Busy falls (cycle after edge k+N) is accepted at edge k+N+1. There is no dead cycle.
- Reset mid-operation: the reset edge aborts the operation, clears HI/LO, and drops Busy in the next cycle. The pending result is discarded.
- Reset has priority over Start on the same edge.
- Operands are captured at acceptance; changes to A/B/MDOp while Busy=1 have no effect on the result.

## Test plan
- Reset, then mult with A=0xFFFFFFFE (-2), B=3, Start for 1 cycle.
  - Busy=1 for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - HI/LO stay 0 during the busy period.
- multu with A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div with A=0xFFFFFFF9 (-7), B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu with A=7, B=0, starting from HI=0x11, LO=0x22 -> Busy high for 10 cycles, then HI=0x11, LO=0x22.
- Busy-period behaviour:
  - Start mtlo with A=0x1234 while Busy=1 -> ignored; LO takes only the division result.
  - The same mtlo issued after Busy=0 -> LO=0x1234 next cycle, Busy stays 0.
- Reset mid-operation:
  - mult A=5, B=6 accepted, reset asserted on the 3rd busy cycle -> Busy=0 and HI=LO=0 next cycle; 30 never appears on LO.
  - A following divu A=0x80000000, B=0xFFFFFFFF -> LO=0, HI=0x80000000.

Source files
------------

// File: rtl/mult_div_if.sv
// Operand/result bundle between the ID/EX operand buses and the multiply/divide unit.
// The master drives operands and the op request; the slave returns Busy and HI/LO.
interface mult_div_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  MDOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output A, output B, output MDOp, output Start,
                  input Busy, input HI, input LO);
  modport slave  (input A, input B, input MDOp, input Start,
                  output Busy, output HI, output LO);
endinterface

// File: rtl/mult_div.sv
// Fixed-latency multiply/divide unit with a HI/LO register pair.
// The result is computed at acceptance and held in PHI/PLO until the busy count expires.
module mult_div #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic      clk,
  input logic      reset,
  mult_div_if.slave md
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_CNT = MULT_CYCLES[3:0];
  localparam logic [3:0] DIV_CNT  = DIV_CYCLES[3:0];

  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] phi_q, phi_d, plo_q, plo_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, sdiv, udiv;
  logic [31:0] q_mag, r_mag, quot_s, rem_s, quot_u, rem_u;

  assign prod_s = {{32{md.A[31]}}, md.A} * {{32{md.B[31]}}, md.B};
  assign prod_u = {32'd0, md.A} * {32'd0, md.B};

  // Signed divide on magnitudes: sidesteps the host trap on 0x80000000 / -1 and
  // naturally yields quotient 0x80000000, remainder 0 for that case.
  assign a_neg  = md.A[31];
  assign b_neg  = md.B[31];
  assign a_mag  = a_neg ? (~md.A + 32'd1) : md.A;
  assign b_mag  = b_neg ? (~md.B + 32'd1) : md.B;
  assign sdiv   = (md.B == 32'd0) ? 32'd1 : b_mag;
  assign udiv   = (md.B == 32'd0) ? 32'd1 : md.B;
  assign q_mag  = a_mag / sdiv;
  assign r_mag  = a_mag % sdiv;
  assign quot_s = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem_s  = a_neg ? (~r_mag + 32'd1) : r_mag;
  assign quot_u = md.A / udiv;
  assign rem_u  = md.A % udiv;

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    phi_d = phi_q;
    plo_d = plo_q;
    cnt_d = cnt_q;
    if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        hi_d = phi_q;
        lo_d = plo_q;
      end
    end else if (md.Start) begin
      case (md.MDOp)
        OP_MULT: begin
          {phi_d, plo_d} = prod_s;
          cnt_d = MULT_CNT;
        end
        OP_MULTU: begin
          {phi_d, plo_d} = prod_u;
          cnt_d = MULT_CNT;
        end
        OP_DIV: begin
          if (md.B == 32'd0) {phi_d, plo_d} = {hi_q, lo_q};
          else               {phi_d, plo_d} = {rem_s, quot_s};
          cnt_d = DIV_CNT;
        end
        OP_DIVU: begin
          if (md.B == 32'd0) {phi_d, plo_d} = {hi_q, lo_q};
          else               {phi_d, plo_d} = {rem_u, quot_u};
          cnt_d = DIV_CNT;
        end
        OP_MTHI: hi_d = md.A;
        OP_MTLO: lo_d = md.A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
      phi_q <= 32'd0;
      plo_q <= 32'd0;
      cnt_q <= 4'd0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      phi_q <= phi_d;
      plo_q <= plo_d;
      cnt_q <= cnt_d;
    end
  end

  assign md.Busy = (cnt_q != 4'd0);
  assign md.HI   = hi_q;
  assign md.LO   = lo_q;

endmodule

// File: tb/tb_mult_div.sv
// Directed-vector bench for mult_div: table of ops with hand-computed HI/LO,
// plus sequences for busy-period ignore, back-to-back issue and mid-op reset.
module tb_mult_div;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_pass  = 0;
  logic [31:0] cur_hi, cur_lo;

  always #5 clk = ~clk;

  mult_div_if md_if ();

  mult_div #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk  (clk),
    .reset(reset),
    .md   (md_if)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Called at a negedge; leaves the bench at the negedge where the result is visible.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input string tag);
    md_if.Start = 1'b1;
    md_if.MDOp  = op;
    md_if.A     = a;
    md_if.B     = b;
    @(negedge clk);
    md_if.Start = 1'b0;
    md_if.A     = $urandom;
    md_if.B     = $urandom;
    for (int i = 0; i < lat; i++) begin
      chk({tag, " busy"}, {31'd0, md_if.Busy}, 32'd1);
      chk({tag, " hold_hi"}, md_if.HI, cur_hi);
      chk({tag, " hold_lo"}, md_if.LO, cur_lo);
      @(negedge clk);
    end
    chk({tag, " idle"}, {31'd0, md_if.Busy}, 32'd0);
    chk({tag, " hi"}, md_if.HI, exp_hi);
    chk({tag, " lo"}, md_if.LO, exp_lo);
    cur_hi = exp_hi;
    cur_lo = exp_lo;
  endtask

  initial begin
    vecs[0]  = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{3'd5, 32'h00000011, 32'h00000000, 32'h00000011, 32'hFFFFFFFD, 0};
    vecs[4]  = '{3'd6, 32'h00000022, 32'h00000000, 32'h00000011, 32'h00000022, 0};
    vecs[5]  = '{3'd4, 32'h00000007, 32'h00000000, 32'h00000011, 32'h00000022, 10};
    vecs[6]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[7]  = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[8]  = '{3'd4, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 10};
    vecs[9]  = '{3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
    vecs[10] = '{3'd0, 32'h12345678, 32'h00000001, 32'h00000001, 32'h00000000, 0};
    vecs[11] = '{3'd7, 32'h12345678, 32'h00000001, 32'h00000001, 32'h00000000, 0};
    vecs[12] = '{3'd3, 32'h00000005, 32'h00000000, 32'h00000001, 32'h00000000, 10};
    vecs[13] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[14] = '{3'd2, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 5};

    reset       = 1'b1;
    md_if.Start = 1'b0;
    md_if.MDOp  = 3'd0;
    md_if.A     = 32'd0;
    md_if.B     = 32'd0;
    cur_hi      = 32'd0;
    cur_lo      = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset busy", {31'd0, md_if.Busy}, 32'd0);
    chk("reset hi", md_if.HI, 32'd0);
    chk("reset lo", md_if.LO, 32'd0);

    for (int v = 0; v < 15; v++)
      run_op(vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].lat, vecs[v].hi, vecs[v].lo,
             $sformatf("vec%0d", v));

    // mtlo issued while a divide is busy must be dropped.
    md_if.Start = 1'b1;
    md_if.MDOp  = 3'd4;
    md_if.A     = 32'd100;
    md_if.B     = 32'd7;
    @(negedge clk);
    md_if.MDOp = 3'd6;
    md_if.A    = 32'h1234;
    for (int i = 0; i < 10; i++) begin
      chk("ign busy", {31'd0, md_if.Busy}, 32'd1);
      chk("ign lo_hold", md_if.LO, cur_lo);
      if (i == 5) md_if.Start = 1'b0;
      @(negedge clk);
    end
    chk("ign idle", {31'd0, md_if.Busy}, 32'd0);
    chk("ign hi", md_if.HI, 32'd2);
    chk("ign lo", md_if.LO, 32'd14);
    cur_hi = 32'd2;
    cur_lo = 32'd14;
    run_op(3'd6, 32'h1234, 32'd0, 0, 32'd2, 32'h1234, "mtlo_after");

    // Start held through the busy period is taken on the cycle Busy falls.
    md_if.Start = 1'b1;
    md_if.MDOp  = 3'd1;
    md_if.A     = 32'd3;
    md_if.B     = 32'd4;
    @(negedge clk);
    md_if.MDOp = 3'd2;
    md_if.A    = 32'd2;
    md_if.B    = 32'd5;
    for (int i = 0; i < 5; i++) begin
      chk("b2b busy1", {31'd0, md_if.Busy}, 32'd1);
      @(negedge clk);
    end
    chk("b2b gap", {31'd0, md_if.Busy}, 32'd0);
    chk("b2b lo1", md_if.LO, 32'd12);
    @(negedge clk);
    md_if.Start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("b2b busy2", {31'd0, md_if.Busy}, 32'd1);
      chk("b2b lo_hold", md_if.LO, 32'd12);
      @(negedge clk);
    end
    chk("b2b idle", {31'd0, md_if.Busy}, 32'd0);
    chk("b2b lo2", md_if.LO, 32'd10);
    cur_hi = 32'd0;
    cur_lo = 32'd10;

    // Reset on the 3rd busy cycle discards the pending 30.
    run_op(3'd5, 32'hAB, 32'd0, 0, 32'hAB, 32'd10, "mthi_pre");
    md_if.Start = 1'b1;
    md_if.MDOp  = 3'd1;
    md_if.A     = 32'd5;
    md_if.B     = 32'd6;
    @(negedge clk);
    md_if.Start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst busy3", {31'd0, md_if.Busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst busy", {31'd0, md_if.Busy}, 32'd0);
    chk("rst hi", md_if.HI, 32'd0);
    chk("rst lo", md_if.LO, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst no30", md_if.LO, 32'd0);
    end
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 10, 32'h80000000, 32'd0, "divu_post");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
